// File: rtl/lcd_cmd_scheduler.sv
// lcd_cmd_scheduler: queues host commands in a small FIFO and issues them to the
// LCD image controller one at a time, only while the controller is idle. A LOAD
// streams IMG_PIXELS pixels from the image memory. Every command then waits for
// FRAME_PIXELS controller output strobes before the next command may issue.
// Ports: host_cmd/_valid/_ready (push side), img_rd_en/_addr/_data (image memory),
//        lcd_cmd/_valid, lcd_datain, lcd_busy, lcd_output_valid (controller side),
//        sched_idle, frame_done, cmd_drop, timeout_err (status).
// Optional build macro LCD_SCHED_TIMEOUT_EN adds a watchdog on WAIT_FRAME that
// raises a sticky timeout_err. Without the macro, timeout_err is tied low.
// Latency: a push into an empty, idle scheduler issues two edges later.
// Backpressure: host_cmd_ready is low while the FIFO is full.
module lcd_cmd_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int IMG_PIXELS     = 108,
  parameter int FRAME_PIXELS   = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] host_cmd,
  input  logic       host_cmd_valid,
  output logic       host_cmd_ready,
  output logic       img_rd_en,
  output logic [6:0] img_rd_addr,
  input  logic [7:0] img_rd_data,
  output logic [3:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  output logic [7:0] lcd_datain,
  input  logic       lcd_busy,
  input  logic       lcd_output_valid,
  output logic       sched_idle,
  output logic       frame_done,
  output logic       cmd_drop,
  output logic       timeout_err
);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int FCW = $clog2(FRAME_PIXELS + 1);
  localparam logic [3:0] CMD_LOAD = 4'd0;
  localparam logic [3:0] CMD_MAX  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM, S_WAIT} state_t;
  state_t r_state, w_state_nxt;

  logic [3:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count, w_count_nxt;
  logic           r_full, r_empty;
  logic           w_push, w_pop;
  logic [3:0]     w_head;
  logic           w_head_bad;
  logic [3:0]     r_cmd;
  logic [7:0]     r_addr;
  logic           r_rd_vld;
  logic [7:0]     r_datain;
  logic [FCW-1:0] r_frame_cnt;
  logic           w_frame_hit;
  logic           r_frame_done;
`ifdef LCD_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] r_wd_cnt;
  logic           r_timeout_err;
  logic           w_wd_hit;
`endif

  assign w_push         = host_cmd_valid && !r_full;
  assign w_head         = r_mem[r_rd_ptr];
  assign w_head_bad     = (w_head > CMD_MAX);
  assign host_cmd_ready = !r_full;
  assign sched_idle     = r_empty && (r_state == S_IDLE);
  assign frame_done     = r_frame_done;
  // The image memory output is already a register; it is forwarded in the cycle
  // it arrives and a local copy holds the last pixel once the stream stops.
  assign lcd_datain     = r_rd_vld ? img_rd_data : r_datain;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= host_cmd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    lcd_cmd       = 4'd0;
    lcd_cmd_valid = 1'b0;
    img_rd_en     = 1'b0;
    img_rd_addr   = 7'd0;
    w_pop         = 1'b0;
    cmd_drop      = 1'b0;
    w_frame_hit   = 1'b0;
`ifdef LCD_SCHED_TIMEOUT_EN
    w_wd_hit      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // Invalid codes never reach the controller, so they are discarded
        // without waiting for it to go idle.
        if (!r_empty) begin
          if (w_head_bad) begin
            w_pop    = 1'b1;
            cmd_drop = 1'b1;
          end else if (!lcd_busy) begin
            w_pop       = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        lcd_cmd       = r_cmd;
        lcd_cmd_valid = 1'b1;
        if (r_cmd == CMD_LOAD) begin
          img_rd_en   = 1'b1;
          w_state_nxt = S_STREAM;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_STREAM: begin
        // One extra cycle after the last address lets the final pixel reach
        // the controller before the frame wait starts.
        if (r_addr < 8'(IMG_PIXELS)) begin
          img_rd_en   = 1'b1;
          img_rd_addr = r_addr[6:0];
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lcd_output_valid && (r_frame_cnt == FCW'(FRAME_PIXELS - 1))) begin
          w_frame_hit = 1'b1;
          w_state_nxt = S_IDLE;
        end
`ifdef LCD_SCHED_TIMEOUT_EN
        else if (r_wd_cnt == WDW'(TIMEOUT_CYCLES - 1)) begin
          w_wd_hit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_cmd        <= 4'd0;
      r_addr       <= 8'd0;
      r_rd_vld     <= 1'b0;
      r_datain     <= 8'd0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
      r_empty <= (w_count_nxt == CW'(0));
      if (w_pop && !w_head_bad) r_cmd <= w_head;
      // ISSUE reads address 0, so the stream proper starts at 1.
      if (r_state == S_ISSUE)  r_addr <= 8'd1;
      else if (img_rd_en)      r_addr <= r_addr + 8'd1;
      r_rd_vld <= img_rd_en;
      if (r_rd_vld) r_datain <= img_rd_data;
      if (r_state != S_WAIT)        r_frame_cnt <= '0;
      else if (lcd_output_valid)    r_frame_cnt <= r_frame_cnt + FCW'(1);
      r_frame_done <= w_frame_hit;
    end
  end

`ifdef LCD_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != S_WAIT) r_wd_cnt <= '0;
      else                   r_wd_cnt <= r_wd_cnt + WDW'(1);
      if (w_wd_hit) r_timeout_err <= 1'b1;
    end
  end
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Directed bench for lcd_cmd_scheduler: issued commands are checked against a
// queue of expected codes, LOAD pixels against the image memory contents.
module tb_lcd_cmd_scheduler;
  localparam int IMG_PIXELS = 108;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] host_cmd = 4'd0;
  logic       host_cmd_valid = 1'b0;
  logic       host_cmd_ready;
  logic       img_rd_en;
  logic [6:0] img_rd_addr;
  logic [7:0] img_rd_data = 8'd0;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic [7:0] lcd_datain;
  logic       lcd_busy = 1'b0;
  logic       lcd_output_valid = 1'b0;
  logic       sched_idle;
  logic       frame_done;
  logic       cmd_drop;
  logic       timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_drop = 0;
  int n_fd = 0;
  int pix_k = -1;
  logic [3:0] sb[$];
  logic [7:0] mem [128];

  lcd_cmd_scheduler dut (
    .clk(clk), .reset(reset),
    .host_cmd(host_cmd), .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .lcd_datain(lcd_datain),
    .lcd_busy(lcd_busy), .lcd_output_valid(lcd_output_valid),
    .sched_idle(sched_idle), .frame_done(frame_done), .cmd_drop(cmd_drop),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Synchronous image memory: data appears the cycle after the read strobe.
  always @(posedge clk) if (img_rd_en) img_rd_data <= mem[img_rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c);
    host_cmd = c;
    host_cmd_valid = 1'b1;
    step();
    host_cmd_valid = 1'b0;
  endtask

  task automatic wait_issue();
    for (int i = 0; i < 40 && lcd_cmd_valid !== 1'b1; i++) step();
    chk("issue_seen", 32'(lcd_cmd_valid), 32'd1);
  endtask

  // Called in the first WAIT_FRAME cycle; ends in the frame_done cycle.
  task automatic do_frame();
    for (int i = 0; i < 16; i++) begin
      lcd_output_valid = 1'b1;
      step();
      chk("frame_done", 32'(frame_done), 32'(i == 15));
    end
    lcd_output_valid = 1'b0;
  endtask

  // Scoreboard and pixel monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      pix_k = -1;
    end else begin
      if (pix_k >= 0) begin
        chk("pixel", 32'(lcd_datain), 32'(mem[pix_k]));
        pix_k++;
        if (pix_k == IMG_PIXELS) pix_k = -1;
      end
      if (cmd_drop) n_drop++;
      if (frame_done) n_fd++;
      if (lcd_cmd_valid) begin
        chk("issue_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) chk("issue_cmd", 32'(lcd_cmd), 32'(sb.pop_front()));
        if (lcd_cmd == 4'd0) pix_k = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = (k < IMG_PIXELS) ? 8'(k) : 8'hEE;

    // Reset values
    step(); step();
    chk("rst_ready", 32'(host_cmd_ready), 32'd1);
    chk("rst_idle", 32'(sched_idle), 32'd1);
    chk("rst_cmd_valid", 32'(lcd_cmd_valid), 32'd0);
    chk("rst_cmd", 32'(lcd_cmd), 32'd0);
    chk("rst_rd_en", 32'(img_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(img_rd_addr), 32'd0);
    chk("rst_datain", 32'(lcd_datain), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_drop", 32'(cmd_drop), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b0;

    // LOAD: push-to-issue latency, address sweep, drain cycle, frame
    sb.push_back(4'd0);
    push(4'd0);
    chk("issue_early", 32'(lcd_cmd_valid), 32'd0);
    step();
    chk("load_valid", 32'(lcd_cmd_valid), 32'd1);
    chk("load_rd_en", 32'(img_rd_en), 32'd1);
    chk("load_addr0", 32'(img_rd_addr), 32'd0);
    lcd_busy = 1'b1;
    sb.push_back(4'd2);
    host_cmd = 4'd2;
    host_cmd_valid = 1'b1;
    for (int k = 1; k < IMG_PIXELS; k++) begin
      step();
      host_cmd_valid = 1'b0;
      chk("stream_addr", 32'(img_rd_addr), 32'(k));
      chk("stream_en", 32'(img_rd_en), 32'd1);
    end
    step();
    chk("drain_en", 32'(img_rd_en), 32'd0);
    lcd_output_valid = 1'b1;  // lands in the drain cycle, must not count
    step();
    chk("hold_last_pixel", 32'(lcd_datain), 32'(mem[IMG_PIXELS-1]));
    do_frame();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("busy_blocks_issue", 32'(lcd_cmd_valid), 32'd0);
    end
    lcd_busy = 1'b0;
    step();
    chk("rot_valid", 32'(lcd_cmd_valid), 32'd1);
    chk("rot_no_rd", 32'(img_rd_en), 32'd0);
    step();
    do_frame();
    chk("idle_after_rot", 32'(sched_idle), 32'd1);

    // FIFO full: five pushes with the controller busy
    lcd_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] codes [5];
      codes = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd7};
      host_cmd = codes[i];
      host_cmd_valid = 1'b1;
      chk("fill_ready", 32'(host_cmd_ready), 32'(i < 4));
      if (i < 4) sb.push_back(codes[i]);
      step();
    end
    host_cmd_valid = 1'b0;
    chk("full_ready", 32'(host_cmd_ready), 32'd0);
    chk("full_not_idle", 32'(sched_idle), 32'd0);
    lcd_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_issue();
      step();
      do_frame();
    end
    chk("drain_idle", 32'(sched_idle), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // Invalid code between two valid ones
    n_drop = 0;
    lcd_busy = 1'b1;
    sb.push_back(4'd3);
    sb.push_back(4'd5);
    push(4'd3);
    push(4'd12);
    push(4'd5);
    lcd_busy = 1'b0;
    wait_issue();
    step();
    do_frame();
    wait_issue();
    step();
    do_frame();
    chk("drop_count", 32'(n_drop), 32'd1);
    chk("sb_empty_drop", 32'(sb.size()), 32'd0);

    // Reset in the middle of a LOAD stream
    sb.push_back(4'd0);
    push(4'd0);
    push(4'd6);
    wait_issue();
    for (int i = 0; i < 60 && img_rd_addr !== 7'd50; i++) step();
    chk("reached_addr50", 32'(img_rd_addr), 32'd50);
    reset = 1'b1;
    #1;
    chk("arst_rd_en", 32'(img_rd_en), 32'd0);
    chk("arst_cmd_valid", 32'(lcd_cmd_valid), 32'd0);
    chk("arst_ready", 32'(host_cmd_ready), 32'd1);
    chk("arst_idle", 32'(sched_idle), 32'd1);
    sb.delete();
    step(); step();
    reset = 1'b0;
    sb.push_back(4'd0);
    push(4'd0);
    chk("reissue_early", 32'(lcd_cmd_valid), 32'd0);
    step();
    chk("reissue_valid", 32'(lcd_cmd_valid), 32'd1);
    chk("reissue_addr0", 32'(img_rd_addr), 32'd0);
    repeat (IMG_PIXELS + 1) step();
    do_frame();
    chk("reset_test_idle", 32'(sched_idle), 32'd1);
    chk("sb_empty_reset", 32'(sb.size()), 32'd0);

`ifdef LCD_SCHED_TIMEOUT_EN
    // Watchdog: only 10 of 16 strobes arrive
    n_fd = 0;
    sb.push_back(4'd4);
    push(4'd4);
    wait_issue();
    step();
    for (int i = 0; i < 10; i++) begin
      lcd_output_valid = 1'b1;
      step();
    end
    lcd_output_valid = 1'b0;
    repeat (245) step();
    chk("wd_before", 32'(timeout_err), 32'd0);
    step();
    chk("wd_err", 32'(timeout_err), 32'd1);
    chk("wd_idle", 32'(sched_idle), 32'd1);
    chk("wd_no_frame", 32'(n_fd), 32'd0);
`endif

    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
